// File: rtl/piso_shift_register_tx_if.sv
// Load handshake and serial output bundle for piso_shift_register_tx.
// The master side is the parallel source; the slave side is the transmitter.
interface piso_shift_register_tx_if #(
  parameter int N = 8
);
  logic [N-1:0] d;
  logic         load_valid;
  logic         load_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         busy;
  logic         done;

  modport master (
    output d, load_valid,
    input  load_ready, serial_out, serial_valid, busy, done
  );

  modport slave (
    input  d, load_valid,
    output load_ready, serial_out, serial_valid, busy, done
  );
endinterface

// File: rtl/piso_shift_register_tx.sv
// Parallel-in serial-out transmitter with a valid/ready load and back-to-back frames.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_register_tx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  piso_shift_register_tx_if.slave  bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = N + 1;
`else
  localparam int FRAME_LEN = N;
`endif
  localparam int                CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_n;
  logic [FRAME_LEN-1:0]   sreg_q, sreg_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic                   sv_q;
  logic                   load_ready;
  logic                   accept;
  logic                   last_bit;

  // Frame image arranged so the first bit to send sits at the output end.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [N-1:0] w);
`ifdef PISO_PARITY_EN
    if (MSB_FIRST) return {w, ^w};
    else           return {^w, w};
`else
    return w;
`endif
  endfunction

  function automatic logic [FRAME_LEN-1:0] advance(input logic [FRAME_LEN-1:0] r);
    if (MSB_FIRST) return {r[FRAME_LEN-2:0], 1'b0};
    else           return {1'b0, r[FRAME_LEN-1:1]};
  endfunction

  assign last_bit   = (state_q == SHIFT) && (cnt_q == '0);
  assign load_ready = !rst && ((state_q == IDLE) || last_bit);
  assign accept     = bus.load_valid && load_ready;

  always_comb begin
    state_n = state_q;
    sreg_n  = sreg_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          sreg_n  = build_frame(bus.d);
          cnt_n   = CNT_LAST;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sreg_n = advance(sreg_q);
          cnt_n  = cnt_q - 1'b1;
        end else if (accept) begin
          // Reload on the final bit so the next frame follows with no gap.
          sreg_n = build_frame(bus.d);
          cnt_n  = CNT_LAST;
        end else begin
          state_n = IDLE;
          sreg_n  = advance(sreg_q);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- register stage: state, shift register, bit counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      sreg_q  <= sreg_n;
      cnt_q   <= cnt_n;
      sv_q    <= (state_n == SHIFT);
    end
  end

  // Zero fill guarantees the output end reads 0 whenever no frame is active.
  assign bus.serial_out   = MSB_FIRST ? sreg_q[FRAME_LEN-1] : sreg_q[0];
  assign bus.serial_valid = sv_q;
  assign bus.busy         = (state_q == SHIFT);
  assign bus.done         = last_bit;
  assign bus.load_ready   = load_ready;

endmodule

// File: tb/tb_piso_shift_register_tx.sv
// Scoreboard bench for piso_shift_register_tx: MSB-first unit (queue + monitor)
// and an LSB-first unit for bit-order checks. Honors PISO_PARITY_EN.
module tb_piso_shift_register_tx;
  localparam int N = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_shift_register_tx_if #(.N(N)) bus_a ();
  piso_shift_register_tx_if #(.N(N)) bus_b ();

  piso_shift_register_tx #(.N(N), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  piso_shift_register_tx #(.N(N), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {logic b; logic dn;} exp_t;
  exp_t q[$];

  int n_pass = 0;
  int n_chk  = 0;
  int cyc = 0, run_len = 0, max_run = 0, done_last = 0, done_prev = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Expected MSB-first frame: data bits high to low, then even parity when enabled.
  function automatic void push_frame(input logic [N-1:0] w, input int nb);
    exp_t e;
    for (int i = 0; i < FL && i < nb; i++) begin
      e.b  = (i < N) ? w[N-1-i] : ^w;
      e.dn = (i == FL - 1);
      q.push_back(e);
    end
  endfunction

  task automatic send(input logic [N-1:0] w, input int nb);
    int k = 0;
    @(negedge clk);
    bus_a.d = w;
    bus_a.load_valid = 1'b1;
    #1;
    while (!bus_a.load_ready && k < 4 * FL) begin
      @(negedge clk); #1; k++;
    end
    chk("send_ready", bus_a.load_ready, 1);
    if (bus_a.load_ready) push_frame(w, nb);
    @(posedge clk); #1;
    bus_a.load_valid = 1'b0;
    bus_a.d = ~w;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.serial_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      chk("queue_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("serial_out", bus_a.serial_out, e.b);
        chk("done", bus_a.done, e.dn);
        chk("busy", bus_a.busy, 1);
      end
    end else begin
      run_len = 0;
      chk("idle_outputs", {bus_a.busy, bus_a.done, bus_a.serial_out}, 3'b000);
    end
    if (bus_a.done) begin
      done_prev = done_last;
      done_last = cyc;
    end
  end

  initial begin
    int nv;
    int k;
    bus_a.d = '0; bus_a.load_valid = 1'b0;
    bus_b.d = '0; bus_b.load_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {bus_a.serial_valid, bus_a.busy, bus_a.done, bus_a.serial_out}, 4'b0000);
    chk("rst_ready_low", bus_a.load_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus_a.load_ready, 1);

    // 1: A5 MSB first, idle on cycle FL+1
    send(8'hA5, FL);
    repeat (FL) @(posedge clk);
    #1;
    chk("t1_idle_busy", bus_a.busy, 0);
    chk("t1_drained", q.size(), 0);

    // 2: LSB-first unit, d=01 -> 1 then zeros
    @(negedge clk);
    bus_b.d = 8'h01;
    bus_b.load_valid = 1'b1;
    #1;
    chk("t2_ready", bus_b.load_ready, 1);
    @(posedge clk); #1;
    bus_b.load_valid = 1'b0;
    bus_b.d = 8'hFE;
    nv = 0;
    for (int i = 0; i < FL + 3; i++) begin
      @(negedge clk);
      if (bus_b.serial_valid) begin
        chk("t2_bit", bus_b.serial_out, (nv == 0 || nv == 8) ? 1 : 0);
        nv++;
      end
    end
    chk("t2_valid_count", nv, FL);

    // 3: back-to-back A5 then 3C
    max_run = 0; done_last = 0; done_prev = 0;
    send(8'hA5, FL);
    send(8'h3C, FL);
    repeat (FL + 3) @(posedge clk);
    #1;
    chk("t3_contiguous", max_run, 2 * FL);
    chk("t3_done_spacing", done_last - done_prev, FL);

    // 4: FF held valid during an 00 frame
    send(8'h00, FL);
    bus_a.d = 8'hFF;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < FL - 1; i++) begin
      chk("t4_ready_low", bus_a.load_ready, 0);
      @(posedge clk); #1;
    end
    send(8'hFF, FL);
    repeat (FL + 2) @(posedge clk);

    // 5: reset during bit 4 of F0
    send(8'hF0, 4);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_ready_in_rst", bus_a.load_ready, 0);
    @(posedge clk); #1;
    chk("t5_after_rst", {bus_a.serial_valid, bus_a.busy, bus_a.done, bus_a.serial_out}, 4'b0000);
    rst = 1'b0;
    send(8'hF0, FL);
    repeat (FL + 2) @(posedge clk);

`ifdef PISO_PARITY_EN
    // 6: parity bit after data
    send(8'hA5, FL);
    send(8'h07, FL);
    repeat (FL + 2) @(posedge clk);
`endif

    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk); k++;
    end
    chk("final_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
